// File: rtl/ppl_pixel_writer.sv
// Ray-march pipeline sink: fetches the texel for each pixel and buffers writes to the framebuffer.
// Drops pixels on FIFO overflow and flags them, because the pipeline cannot be stalled.
module ppl_pixel_writer #(
  parameter int unsigned H_DISP     = 1280,
  parameter int unsigned V_DISP     = 720,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] COLOR_KEY  = 16'hF81F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [19:0] in_pixel_addr,
  input  logic [12:0] in_texture_addr,
  output logic [12:0] tex_addr,
  input  logic [15:0] tex_data,
  output logic        fb_wr_en,
  output logic [19:0] fb_wr_addr,
  output logic [15:0] fb_wr_data,
  input  logic        fb_wr_ready,
  output logic [4:0]  fifo_level,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [15:0] drop_cnt,
  output logic        frame_done
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned LW        = PW + 1;
  localparam logic [19:0] LAST_ADDR = 20'(H_DISP * V_DISP - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  logic          r_s1_valid;
  logic [19:0]   r_s1_addr;
  logic [19:0]   r_mem_addr [FIFO_DEPTH];
  logic [15:0]   r_mem_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;
  logic          r_frame_done;

  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_wr_en;

  assign tex_addr = in_texture_addr;

  // Write enable is masked during reset so nothing leaves the FIFO in the reset cycle.
  assign w_wr_en    = (r_level != '0) && !rst;
  assign w_pop      = w_wr_en && fb_wr_ready;
  assign w_push_req = r_s1_valid && (r_s1_addr <= LAST_ADDR) && (tex_data != COLOR_KEY);
  assign w_push     = w_push_req && ((r_level < DEPTH_L) || w_pop);
  assign w_drop     = w_push_req && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_addr  <= in_pixel_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= r_s1_addr;
      r_mem_data[r_wr_ptr] <= tex_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop coinciding with a clear restarts the count at one rather than zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (ovf_clr)                r_drop_cnt <= 16'd1;
      else if (r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_frame_done <= 1'b0;
    else     r_frame_done <= w_pop && (r_mem_addr[r_rd_ptr] == LAST_ADDR);
  end

  assign fb_wr_en   = w_wr_en;
  assign fb_wr_addr = r_mem_addr[r_rd_ptr];
  assign fb_wr_data = r_mem_data[r_rd_ptr];
  assign fifo_level = 5'(r_level);
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
  assign frame_done = r_frame_done;

endmodule

// File: doc/ppl_pixel_writer.md
Name: ppl_pixel_writer

Overview:
- Sink side of the ray-march pipeline output.
- Consumes the pipeline's pixel stream (valid, pixel address, texture address) and fetches the texel from the synchronous texture ROM.
- Buffers {pixel address, texel} in an internal FIFO and drains it to the framebuffer write port under a ready/enable handshake.
- The pipeline has no backpressure, so the block absorbs bursts, drops on overflow, and flags every drop.

Parameters:
H_DISP, 1280, horizontal resolution in pixels
V_DISP, 720, vertical resolution in pixels
FIFO_DEPTH, 16, entries in the write FIFO (power of 2, >= 4)
COLOR_KEY, 16'hF81F, RGB565 texel value treated as transparent and never written

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
in_valid  in  1  pipeline output pixel valid
in_pixel_addr  in  20  framebuffer address, row-major y*H_DISP+x
in_texture_addr  in  13  texture ROM address for this pixel
tex_addr  out  13  texture ROM read address; equals in_texture_addr combinationally
tex_data  in  16  RGB565 texel, valid one cycle after tex_addr
fb_wr_en  out  1  framebuffer write request
fb_wr_addr  out  20  framebuffer write address
fb_wr_data  out  16  framebuffer write data (RGB565)
fb_wr_ready  in  1  framebuffer accepts the write when high with fb_wr_en
fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: at least one pixel was dropped because the FIFO was full
ovf_clr  in  1  clears overflow and drop_cnt
drop_cnt  out  16  saturating count of dropped pixels
frame_done  out  1  one-cycle pulse after the last pixel address is written

Behaviour:
Reset:
- All outputs are 0: fb_wr_en, fifo_level, overflow, drop_cnt, frame_done.
- FIFO pointers clear; the stage-1 valid clears.
- A reset mid-operation discards all buffered pixels. No write is issued in the reset cycle.

Stage 0 (cycle N):
- tex_addr = in_texture_addr.
- Registered into stage 1: s1_valid <= in_valid, s1_addr <= in_pixel_addr.

Stage 1 (cycle N+1):
- The texel is tex_data.
- A push is requested when s1_valid=1, s1_addr < H_DISP*V_DISP, and tex_data != COLOR_KEY.
- An out-of-range address or a keyed texel is silently discarded. It is not counted as a drop.
- The push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs in the same cycle.
- On refusal: overflow <= 1 and drop_cnt increments, saturating at 16'hFFFF.
- If ovf_clr and a drop happen in the same cycle, the drop wins: overflow=1, drop_cnt=1.

FIFO:
- First-word fall-through.
- fb_wr_en = (occupancy != 0). fb_wr_addr and fb_wr_data present the head entry.
- A pop occurs when fb_wr_en && fb_wr_ready.
- The head entry is stable while fb_wr_en=1 and fb_wr_ready=0.
- fifo_level updates as +1 on push, -1 on pop, unchanged on push and pop together.
- Pointers wrap modulo FIFO_DEPTH.
- Minimum latency from in_valid to fb_wr_en is 2 cycles: register into stage 1, push, visible the next cycle.

frame_done:
- Pulses for one cycle in the cycle after the pop of an entry whose address equals H_DISP*V_DISP-1.
- Does not fire if that pixel was keyed, out of range, or dropped.

Test Plan:
- Single pixel: in_valid=1, in_pixel_addr=100, tex ROM returns 16'h07E0 -> fb_wr_en rises 2 cycles later with addr=100, data=16'h07E0, fb_wr_ready=1 -> fifo_level returns to 0.
- Backpressure: fb_wr_ready=0, 16 consecutive valid pixels at addr 0..15 -> fifo_level=16, overflow=0; a 17th pixel -> overflow=1, drop_cnt=1; release ready -> addrs 0..15 written in order with matching texels.
- Full with simultaneous pop: FIFO full, fb_wr_ready=1, new pixel addr 500 -> accepted, fifo_level stays 16, drop_cnt unchanged.
- Filters: texel 16'hF81F at addr 7 -> no write; addr 921600 (=1280*720) -> no write; drop_cnt stays 0.
- Frame end: pixel addr 921599, texel 16'h001F, ready=1 -> write issued, then frame_done=1 for exactly one cycle.
- Reset and clear: 5 entries buffered, rst=1 for one cycle -> fifo_level=0, fb_wr_en=0, no writes. Then force overflow and assert ovf_clr -> overflow=0, drop_cnt=0 next cycle.
